// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational alu between two requesters.
// Optional ALU_OPCHECK_EN: op 3'b111 is squashed to a zero result with RspError set.
module alu_arbiter #(
   parameter int WIDTH = 16,
   parameter int OPW   = 3
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [1:0]         ReqValid,
   output logic [1:0]         ReqReady,
   input  logic [2*WIDTH-1:0] ReqA,
   input  logic [2*WIDTH-1:0] ReqB,
   input  logic [2*OPW-1:0]   ReqOp,
   output logic [WIDTH-1:0]   AluA,
   output logic [WIDTH-1:0]   AluB,
   output logic [OPW-1:0]     AluOp,
   input  logic [WIDTH-1:0]   AluOut,
   input  logic               CarryOut,
   input  logic               Overflow,
   output logic [1:0]         RspValid,
   input  logic [1:0]         RspReady,
   output logic [WIDTH-1:0]   RspData,
   output logic               RspCarry,
   output logic               RspOverflow,
   output logic               RspError
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } stateT;

   stateT            state;
   logic             grant;
   logic             lastGrant;
   logic             pendErr;
   logic             nextGrant;
   logic             anyValid;
   logic             illegal;
   logic [WIDTH-1:0] selA;
   logic [WIDTH-1:0] selB;
   logic [OPW-1:0]   selOp;

   always_comb begin
      anyValid  = |ReqValid;
      // With both valid, the port that did not win last time goes first.
      nextGrant = (&ReqValid) ? ~lastGrant : ReqValid[1];
      selA      = nextGrant ? ReqA[2*WIDTH-1:WIDTH] : ReqA[WIDTH-1:0];
      selB      = nextGrant ? ReqB[2*WIDTH-1:WIDTH] : ReqB[WIDTH-1:0];
      selOp     = nextGrant ? ReqOp[2*OPW-1:OPW] : ReqOp[OPW-1:0];
`ifdef ALU_OPCHECK_EN
      illegal   = (selOp == {OPW{1'b1}});
`else
      illegal   = 1'b0;
`endif
      ReqReady  = '0;
      if (state == IDLE && anyValid && !Reset)
         ReqReady[nextGrant] = 1'b1;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         grant       <= 1'b0;
         lastGrant   <= 1'b1;
         pendErr     <= 1'b0;
         AluA        <= '0;
         AluB        <= '0;
         AluOp       <= '0;
         RspValid    <= '0;
         RspData     <= '0;
         RspCarry    <= 1'b0;
         RspOverflow <= 1'b0;
         RspError    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (anyValid) begin
                  AluA      <= selA;
                  AluB      <= selB;
                  AluOp     <= illegal ? '0 : selOp;
                  pendErr   <= illegal;
                  grant     <= nextGrant;
                  lastGrant <= nextGrant;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               RspData     <= pendErr ? '0 : AluOut;
               RspCarry    <= pendErr ? 1'b0 : CarryOut;
               RspOverflow <= pendErr ? 1'b0 : Overflow;
               RspError    <= pendErr;
               RspValid    <= {grant, ~grant};
               state       <= RESP;
            end
            RESP: begin
               if (RspReady[grant]) begin
                  RspValid <= '0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
